// File: rtl/soc_riscv_cpu2ahb_scoreboard.sv
// rtl/soc_riscv_cpu2ahb_scoreboard.sv - CPU request vs AHB transfer scoreboard
// Queues CPU memory requests and checks them against AHB address and data phases.
module soc_riscv_cpu2ahb_scoreboard #(
  parameter int XLEN           = 32,
  parameter int PHYS_ADDR_SIZE = XLEN,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [XLEN-1:0]           mem_adr,
  input  logic [XLEN-1:0]           mem_d,
  input  logic                      mem_req,
  input  logic                      mem_we,
  input  logic [XLEN/8-1:0]         mem_be,
  input  logic                      mem_misaligned,
  input  logic                      HSEL,
  input  logic [PHYS_ADDR_SIZE-1:0] HADDR,
  input  logic [XLEN-1:0]           HWDATA,
  input  logic                      HWRITE,
  input  logic [2:0]                HSIZE,
  input  logic [1:0]                HTRANS,
  input  logic                      HREADY,
  input  logic                      HRESP,
  input  logic                      err_clr,
  output logic                      err_addr,
  output logic                      err_write,
  output logic                      err_size,
  output logic                      err_wdata,
  output logic                      err_resp,
  output logic                      err_overflow,
  output logic                      err_underflow,
  output logic                      err_timeout,
  output logic [15:0]               err_count,
  output logic [$clog2(DEPTH):0]    outstanding
);
  localparam int BW = XLEN / 8;
  localparam int PW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [XLEN-1:0] r_adr_q [DEPTH];
  logic            r_we_q  [DEPTH];
  logic [BW-1:0]   r_be_q  [DEPTH];
  logic [XLEN-1:0] r_d_q   [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [PW:0]     r_count;

  logic            r_dp_valid, r_dp_we;
  logic [BW-1:0]   r_dp_be;
  logic [XLEN-1:0] r_dp_d;

  logic [TW-1:0]   r_tmo;
  logic [7:0]      r_err;
  logic [15:0]     r_err_count;

  logic            w_push, w_aphase, w_empty, w_full, w_bypass, w_pop, w_load, w_fifo_wr;
  logic [XLEN-1:0] w_c_adr, w_c_d;
  logic            w_c_we;
  logic [BW-1:0]   w_c_be;
  logic [2:0]      w_exp_size;
  logic            w_done, w_wdata_bad, w_tmo_run;
  logic [7:0]      w_ev;

  assign w_push    = mem_req && !mem_misaligned;
  assign w_aphase  = HREADY && HSEL && (HTRANS == 2'b10 || HTRANS == 2'b11);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == (PW+1)'(DEPTH));
  assign w_bypass  = w_push && w_aphase && w_empty;
  assign w_pop     = w_aphase && !w_empty;
  assign w_load    = w_pop || w_bypass;
  assign w_fifo_wr = w_push && !w_bypass && (!w_full || w_pop);

  // With an empty FIFO the entry being pushed is the one the address phase consumes.
  assign w_c_adr = w_bypass ? mem_adr : r_adr_q[r_rd_ptr];
  assign w_c_we  = w_bypass ? mem_we  : r_we_q[r_rd_ptr];
  assign w_c_be  = w_bypass ? mem_be  : r_be_q[r_rd_ptr];
  assign w_c_d   = w_bypass ? mem_d   : r_d_q[r_rd_ptr];

  always_comb begin
    w_exp_size = 3'b111;
    case ($countones(w_c_be))
      1:       w_exp_size = 3'd0;
      2:       w_exp_size = 3'd1;
      4:       w_exp_size = 3'd2;
      8:       w_exp_size = 3'd3;
      default: w_exp_size = 3'b111;
    endcase
  end

  always_comb begin
    w_wdata_bad = 1'b0;
    for (int i = 0; i < BW; i++) begin
      if (r_dp_be[i] && (HWDATA[8*i +: 8] !== r_dp_d[8*i +: 8])) w_wdata_bad = 1'b1;
    end
  end

  assign w_done    = r_dp_valid && HREADY;
  assign w_tmo_run = !w_empty && !w_pop;

  // Event bits: addr, write, size, wdata, resp, overflow, underflow, timeout.
  assign w_ev[0] = w_load && (HADDR !== w_c_adr[PHYS_ADDR_SIZE-1:0]);
  assign w_ev[1] = w_load && (HWRITE !== w_c_we);
  assign w_ev[2] = w_load && (HSIZE !== w_exp_size);
  assign w_ev[3] = w_done && r_dp_we && w_wdata_bad;
  assign w_ev[4] = w_done && (HRESP !== 1'b0);
  assign w_ev[5] = w_push && w_full && !w_pop;
  assign w_ev[6] = w_aphase && w_empty && !w_push;
  assign w_ev[7] = w_tmo_run && (r_tmo == TW'(TIMEOUT - 1));

  always_ff @(posedge HCLK) begin
    if (w_fifo_wr) begin
      r_adr_q[r_wr_ptr] <= mem_adr;
      r_we_q[r_wr_ptr]  <= mem_we;
      r_be_q[r_wr_ptr]  <= mem_be;
      r_d_q[r_wr_ptr]   <= mem_d;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_dp_valid  <= 1'b0;
      r_dp_we     <= 1'b0;
      r_dp_be     <= '0;
      r_dp_d      <= '0;
      r_tmo       <= '0;
      r_err       <= '0;
      r_err_count <= '0;
    end else begin
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_fifo_wr && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_fifo_wr && w_pop) r_count <= r_count - 1'b1;

      if (w_load) begin
        r_dp_valid <= 1'b1;
        r_dp_we    <= w_c_we;
        r_dp_be    <= w_c_be;
        r_dp_d     <= w_c_d;
      end else if (HREADY) begin
        r_dp_valid <= 1'b0;
      end

      if (err_clr) begin
        r_tmo       <= '0;
        r_err       <= '0;
        r_err_count <= '0;
      end else begin
        if (!w_tmo_run)                       r_tmo <= '0;
        else if (r_tmo != TW'(TIMEOUT))       r_tmo <= r_tmo + 1'b1;
        r_err <= r_err | w_ev;
        if ((w_ev != '0) && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 1'b1;
      end
    end
  end

  assign err_addr      = r_err[0];
  assign err_write     = r_err[1];
  assign err_size      = r_err[2];
  assign err_wdata     = r_err[3];
  assign err_resp      = r_err[4];
  assign err_overflow  = r_err[5];
  assign err_underflow = r_err[6];
  assign err_timeout   = r_err[7];
  assign err_count     = r_err_count;
  assign outstanding   = r_count;
endmodule

// File: tb/tb_soc_riscv_cpu2ahb_scoreboard.sv
// tb/tb_soc_riscv_cpu2ahb_scoreboard.sv - self-checking bench for the CPU-to-AHB scoreboard
module tb_soc_riscv_cpu2ahb_scoreboard;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 8;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b0;
  logic [31:0] mem_adr, mem_d, HADDR, HWDATA;
  logic        mem_req, mem_we, mem_misaligned, HSEL, HWRITE, HREADY, HRESP, err_clr;
  logic [3:0]  mem_be;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        err_addr, err_write, err_size, err_wdata, err_resp;
  logic        err_overflow, err_underflow, err_timeout;
  logic [15:0] err_count;
  logic [2:0]  outstanding;

  always #5 HCLK = ~HCLK;

  soc_riscv_cpu2ahb_scoreboard #(.XLEN(32), .PHYS_ADDR_SIZE(32), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .mem_adr(mem_adr), .mem_d(mem_d), .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_misaligned(mem_misaligned),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .HREADY(HREADY), .HRESP(HRESP), .err_clr(err_clr),
    .err_addr(err_addr), .err_write(err_write), .err_size(err_size), .err_wdata(err_wdata),
    .err_resp(err_resp), .err_overflow(err_overflow), .err_underflow(err_underflow),
    .err_timeout(err_timeout), .err_count(err_count), .outstanding(outstanding)
  );

  // Flag bit order: addr, write, size, wdata, resp, overflow, underflow, timeout.
  wire [7:0]  obs_flags = {err_timeout, err_underflow, err_overflow, err_resp,
                           err_wdata, err_size, err_write, err_addr};
  wire [26:0] obs = {obs_flags, err_count, outstanding};

  typedef struct packed { logic [31:0] adr; logic we; logic [3:0] be; logic [31:0] d; } entry_t;
  entry_t q[$];
  entry_t m_dp;
  bit     m_dp_v;
  bit [7:0] m_flags;
  int     m_cnt, m_tmo;
  int     errors = 0, checks = 0;

  function automatic logic [2:0] exp_size(input logic [3:0] be);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(be[i]);
    case (n)
      1: return 3'd0;
      2: return 3'd1;
      4: return 3'd2;
      default: return 3'd7;
    endcase
  endfunction

  function automatic void model_reset();
    q.delete();
    m_dp_v = 0; m_flags = 0; m_cnt = 0; m_tmo = 0;
  endfunction

  // Reference: one clock edge worth of scoreboard behaviour from the current inputs.
  function automatic void model_step();
    bit aph, push, pop, ld;
    bit [7:0] ev;
    entry_t cur, e;
    int sz0;
    aph  = HREADY && HSEL && HTRANS[1];
    push = mem_req && !mem_misaligned;
    cur  = '{adr: mem_adr, we: mem_we, be: mem_be, d: mem_d};
    sz0  = q.size();
    pop  = aph && sz0 > 0;
    ev = 0; ld = 0; e = '0;
    if (m_dp_v && HREADY) begin
      if (m_dp.we)
        for (int i = 0; i < 4; i++)
          if (m_dp.be[i] && (HWDATA[8*i +: 8] !== m_dp.d[8*i +: 8])) ev[3] = 1;
      if (HRESP !== 1'b0) ev[4] = 1;
    end
    if (aph) begin
      if (sz0 > 0) begin e = q.pop_front(); ld = 1; end
      else if (push) begin e = cur; ld = 1; push = 0; end
      else ev[6] = 1;
      if (ld) begin
        ev[0] = (HADDR !== e.adr);
        ev[1] = (HWRITE !== e.we);
        ev[2] = (HSIZE !== exp_size(e.be));
      end
    end
    if (push) begin
      if (q.size() < DEPTH) q.push_back(cur);
      else ev[5] = 1;
    end
    if (ld) begin m_dp = e; m_dp_v = 1; end
    else if (HREADY) m_dp_v = 0;
    if (sz0 > 0 && !pop) begin
      if (m_tmo < TIMEOUT) begin
        m_tmo++;
        if (m_tmo == TIMEOUT) ev[7] = 1;
      end
    end else m_tmo = 0;
    if (err_clr) begin
      m_flags = 0; m_cnt = 0; m_tmo = 0;
    end else begin
      m_flags |= ev;
      if (ev != 0 && m_cnt < 65535) m_cnt++;
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic cpu(input bit req, input logic [31:0] adr, input bit we, input logic [3:0] be,
                     input logic [31:0] d);
    mem_req = req; mem_adr = adr; mem_we = we; mem_be = be; mem_d = d; mem_misaligned = 0;
  endtask

  task automatic ahb(input bit sel, input logic [1:0] trans, input logic [31:0] addr, input bit wr,
                     input logic [2:0] size, input logic [31:0] wdata, input bit rdy, input bit resp);
    HSEL = sel; HTRANS = trans; HADDR = addr; HWRITE = wr; HSIZE = size;
    HWDATA = wdata; HREADY = rdy; HRESP = resp;
  endtask

  task automatic idle();
    cpu(0, 0, 0, 0, 0);
    ahb(0, 2'b00, 0, 0, 0, 0, 1, 0);
    err_clr = 0;
  endtask

  task automatic do_reset();
    idle();
    HRESET = 1;
    model_reset();
    @(posedge HCLK);
    #1 HRESET = 0;
  endtask

  task automatic test_reset();
    idle();
    HRESET = 0;
    #1 HRESET = 1;
    #1;
    checks++;
    if (obs !== 27'd0) begin errors++; $display("FAIL reset_state: got %h expected %h", obs, 27'd0); end
    model_reset();
    @(posedge HCLK);
    #1 HRESET = 0;
  endtask

  task automatic test_matched_write();
    do_reset();
    cpu(1, 32'h80, 1, 4'hF, 32'h12345678); tick();
    checks++;
    if (obs !== {8'h00, 16'd0, 3'd1}) begin errors++; $display("FAIL matched_push: got %h expected %h", obs, {8'h00, 16'd0, 3'd1}); end
    cpu(0, 0, 0, 0, 0); ahb(1, 2'b10, 32'h80, 1, 3'd2, 0, 1, 0); tick();
    checks++;
    if (obs !== 27'd0) begin errors++; $display("FAIL matched_addr: got %h expected %h", obs, 27'd0); end
    ahb(0, 2'b00, 0, 0, 0, 32'h12345678, 1, 0); tick();
    checks++;
    if (obs !== 27'd0) begin errors++; $display("FAIL matched_data: got %h expected %h", obs, 27'd0); end
  endtask

  task automatic test_byte_write();
    do_reset();
    cpu(1, 32'h84, 1, 4'b0100, 32'h00AB0000); tick();
    cpu(0, 0, 0, 0, 0); ahb(1, 2'b10, 32'h84, 1, 3'd0, 0, 1, 0); tick();
    ahb(0, 2'b00, 0, 0, 0, 32'hFFABFFFF, 1, 0); tick();
    checks++;
    if (obs !== 27'd0) begin errors++; $display("FAIL byte_wdata_ok: got %h expected %h", obs, 27'd0); end
    cpu(1, 32'h84, 1, 4'b0100, 32'h00AB0000); ahb(0, 2'b00, 0, 0, 0, 0, 1, 0); tick();
    cpu(0, 0, 0, 0, 0); ahb(1, 2'b10, 32'h84, 1, 3'd0, 0, 1, 0); tick();
    ahb(0, 2'b00, 0, 0, 0, 32'h00CD0000, 1, 0); tick();
    checks++;
    if (obs !== {8'h08, 16'd1, 3'd0}) begin errors++; $display("FAIL byte_wdata_bad: got %h expected %h", obs, {8'h08, 16'd1, 3'd0}); end
  endtask

  task automatic test_occupancy();
    do_reset();
    cpu(1, 32'h40, 1, 4'hF, 0); mem_misaligned = 1; tick();
    checks++;
    if (obs !== 27'd0) begin errors++; $display("FAIL misaligned_ignored: got %h expected %h", obs, 27'd0); end
    for (int i = 0; i < 5; i++) begin cpu(1, 32'h100 + 4 * i, 0, 4'hF, i); tick(); end
    checks++;
    if (obs !== {8'h20, 16'd1, 3'd4}) begin errors++; $display("FAIL overflow: got %h expected %h", obs, {8'h20, 16'd1, 3'd4}); end
    cpu(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      ahb(1, (i == 0) ? 2'b10 : 2'b11, 32'h100 + 4 * i, 0, 3'd2, 0, 1, 0); tick();
      if (i == 3) begin
        checks++;
        if (obs !== {8'h20, 16'd1, 3'd0}) begin errors++; $display("FAIL drained: got %h expected %h", obs, {8'h20, 16'd1, 3'd0}); end
      end
    end
    checks++;
    if (obs !== {8'h60, 16'd2, 3'd0}) begin errors++; $display("FAIL underflow: got %h expected %h", obs, {8'h60, 16'd2, 3'd0}); end
  endtask

  task automatic test_bypass_pipeline();
    do_reset();
    cpu(1, 32'h200, 1, 4'hF, 32'hCAFEF00D); ahb(1, 2'b10, 32'h200, 1, 3'd2, 0, 1, 0); tick();
    checks++;
    if (obs !== 27'd0) begin errors++; $display("FAIL bypass_addr: got %h expected %h", obs, 27'd0); end
    cpu(0, 0, 0, 0, 0); ahb(0, 2'b00, 0, 0, 0, 32'hCAFEF00D, 1, 0); tick();
    checks++;
    if (obs !== 27'd0) begin errors++; $display("FAIL bypass_data: got %h expected %h", obs, 27'd0); end
    ahb(0, 2'b00, 0, 0, 0, 0, 1, 0);
    cpu(1, 32'h300, 1, 4'hF, 32'h11111111); tick();
    cpu(1, 32'h304, 1, 4'h3, 32'h00002222); tick();
    cpu(0, 0, 0, 0, 0);
    checks++;
    if (obs !== {8'h00, 16'd0, 3'd2}) begin errors++; $display("FAIL pipe_fill: got %h expected %h", obs, {8'h00, 16'd0, 3'd2}); end
    ahb(1, 2'b10, 32'h300, 1, 3'd2, 0, 1, 0); tick();
    ahb(1, 2'b11, 32'h304, 1, 3'd1, 32'hDEADBEEF, 0, 1); tick(); tick();
    checks++;
    if (obs !== {8'h00, 16'd0, 3'd1}) begin errors++; $display("FAIL pipe_wait: got %h expected %h", obs, {8'h00, 16'd0, 3'd1}); end
    ahb(1, 2'b11, 32'h304, 1, 3'd1, 32'h11111111, 1, 0); tick();
    checks++;
    if (obs !== 27'd0) begin errors++; $display("FAIL pipe_b2b: got %h expected %h", obs, 27'd0); end
    ahb(0, 2'b00, 0, 0, 0, 32'hFFFF2222, 1, 0); tick();
    checks++;
    if (obs !== 27'd0) begin errors++; $display("FAIL pipe_last: got %h expected %h", obs, 27'd0); end
  endtask

  task automatic test_timeout_resp_reset();
    do_reset();
    cpu(1, 32'h400, 0, 4'hF, 0); tick();
    cpu(0, 0, 0, 0, 0);
    repeat (7) tick();
    checks++;
    if (obs !== {8'h00, 16'd0, 3'd1}) begin errors++; $display("FAIL timeout_before: got %h expected %h", obs, {8'h00, 16'd0, 3'd1}); end
    tick();
    checks++;
    if (obs !== {8'h80, 16'd1, 3'd1}) begin errors++; $display("FAIL timeout_hit: got %h expected %h", obs, {8'h80, 16'd1, 3'd1}); end
    err_clr = 1; tick(); err_clr = 0;
    checks++;
    if (obs !== {8'h00, 16'd0, 3'd1}) begin errors++; $display("FAIL err_clr: got %h expected %h", obs, {8'h00, 16'd0, 3'd1}); end
    ahb(1, 2'b10, 32'h400, 0, 3'd2, 0, 1, 0); tick();
    ahb(0, 2'b00, 0, 0, 0, 0, 0, 1); tick();
    checks++;
    if (obs !== 27'd0) begin errors++; $display("FAIL resp_wait: got %h expected %h", obs, 27'd0); end
    ahb(0, 2'b00, 0, 0, 0, 0, 1, 1); tick();
    checks++;
    if (obs !== {8'h10, 16'd1, 3'd0}) begin errors++; $display("FAIL resp: got %h expected %h", obs, {8'h10, 16'd1, 3'd0}); end
    ahb(0, 2'b00, 0, 0, 0, 0, 1, 0);
    cpu(1, 32'h500, 0, 4'hF, 0); tick(); tick();
    cpu(0, 0, 0, 0, 0);
    #2 HRESET = 1;
    #1;
    checks++;
    if (obs !== 27'd0) begin errors++; $display("FAIL reset_midstream: got %h expected %h", obs, 27'd0); end
    model_reset();
    @(posedge HCLK);
    #1 HRESET = 0;
    ahb(1, 2'b10, 32'h500, 0, 3'd2, 0, 1, 0); tick();
    checks++;
    if (obs !== {8'h40, 16'd1, 3'd0}) begin errors++; $display("FAIL underflow_after_reset: got %h expected %h", obs, {8'h40, 16'd1, 3'd0}); end
  endtask

  task automatic test_random();
    logic [3:0] be_tab [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
    entry_t ref_e;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      mem_req = ($urandom_range(0, 99) < 45);
      mem_misaligned = ($urandom_range(0, 9) == 0);
      mem_adr = 32'($urandom_range(0, 15)) << 2;
      mem_we = 1'($urandom_range(0, 1));
      mem_be = be_tab[$urandom_range(0, 6)];
      mem_d = $urandom;
      ref_e = (q.size() > 0) ? q[0] : '{adr: mem_adr, we: mem_we, be: mem_be, d: mem_d};
      HSEL = ($urandom_range(0, 99) < 85);
      HTRANS = 2'($urandom_range(0, 3));
      HREADY = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 99) < 80) begin
        HADDR = ref_e.adr; HWRITE = ref_e.we; HSIZE = exp_size(ref_e.be);
      end else begin
        HADDR = 32'($urandom_range(0, 15)) << 2; HWRITE = 1'($urandom_range(0, 1));
        HSIZE = 3'($urandom_range(0, 3));
      end
      HWDATA = (m_dp_v && $urandom_range(0, 99) < 85) ? m_dp.d : $urandom;
      HRESP = ($urandom_range(0, 99) < 5);
      err_clr = ($urandom_range(0, 99) < 3);
      tick();
      checks++;
      if (obs_flags !== m_flags) begin errors++; $display("FAIL rand_flags cycle %0d: got %h expected %h", c, obs_flags, m_flags); end
      checks++;
      if (err_count !== 16'(m_cnt)) begin errors++; $display("FAIL rand_count cycle %0d: got %0d expected %0d", c, err_count, m_cnt); end
      checks++;
      if (outstanding !== 3'(q.size())) begin errors++; $display("FAIL rand_outstanding cycle %0d: got %0d expected %0d", c, outstanding, q.size()); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_matched_write();
    test_byte_write();
    test_occupancy();
    test_bypass_pipeline();
    test_timeout_resp_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/soc_riscv_cpu2ahb_scoreboard.md
SOC_RISCV_CPU2AHB_SCOREBOARD -- requirements
Module: soc_riscv_cpu2ahb_scoreboard

Interface
REQ-001 SHALL have parameters: XLEN, 32, data width (32 or 64); PHYS_ADDR_SIZE, XLEN, AHB address width; DEPTH, 4, expected-transaction FIFO depth (power of 2, >=2); TIMEOUT, 255, maximum cycles the FIFO may stay non-empty without a pop.
REQ-002 SHALL have ports: HCLK in 1 clock; HRESET in 1 reset, asynchronous, active-high.
REQ-003 SHALL have CPU-side inputs: mem_adr XLEN; mem_d XLEN; mem_req 1; mem_we 1; mem_be XLEN/8; mem_misaligned 1.
REQ-004 SHALL have AHB inputs: HSEL 1; HADDR PHYS_ADDR_SIZE; HWDATA XLEN; HWRITE 1; HSIZE 3; HTRANS 2; HREADY 1; HRESP 1.
REQ-005 SHALL have control input: err_clr 1, synchronous clear of all error state.
REQ-006 SHALL have outputs, all registered: err_addr, err_write, err_size, err_wdata, err_resp, err_overflow, err_underflow, err_timeout, 1 bit each, sticky; err_count 16, saturating mismatch count; outstanding $clog2(DEPTH)+1, FIFO occupancy.

Function
REQ-007 Push: SHALL occur at a rising HCLK edge with mem_req=1 and mem_misaligned=0. Entry = {mem_adr, mem_we, mem_be, mem_d}. mem_req with mem_misaligned=1 is ignored.
REQ-008 Address phase: SHALL occur at an edge with HREADY=1, HSEL=1 and HTRANS[1]=1 (NONSEQ/SEQ). IDLE/BUSY are never checked.
REQ-009 At an address phase the FIFO head SHALL pop. Fields compared: HADDR vs adr[PHYS_ADDR_SIZE-1:0] -> err_addr; HWRITE vs we -> err_write; HSIZE vs size derived from be popcount (1->0, 2->1, 4->2, 8->3) -> err_size. All comparisons are 4-state exact; X/Z counts as mismatch.
REQ-010 Bypass: push and address phase on the same edge with the FIFO empty SHALL compare against, and consume, the entry being pushed. Occupancy is unchanged.
REQ-011 Address phase with the FIFO empty and no push SHALL set err_underflow and skip the field checks.
REQ-012 Push with FIFO full and no pop on that edge SHALL drop the entry and set err_overflow. Push+pop on the same edge while full is legal, with no error.
REQ-013 A popped entry SHALL load a data-phase register (dp_valid=1). dp_valid clears at the next edge with HREADY=1 unless a new address phase reloads it on that same edge (pipelined back-to-back).
REQ-014 Data phase completes at an edge with dp_valid=1 and HREADY=1.
- If we=1: HWDATA is compared only on bytes with be=1 -> err_wdata.
- HRESP=1 at completion sets err_resp.
- With HREADY=0, HRESP is ignored.
REQ-015 Timeout counter SHALL increment each edge the FIFO is non-empty and no pop occurs. It resets to 0 on a pop or when the FIFO is empty. On reaching TIMEOUT it sets err_timeout and holds.
REQ-016 err_count SHALL increment by exactly 1 per edge on which one or more error flags newly assert (events, not sticky state). It saturates at 16'hFFFF.
REQ-017 Outputs update one cycle after the triggering edge's inputs, i.e. they are visible after that edge.
REQ-018 err_clr=1 SHALL zero all err_* outputs and the timeout counter. It does not affect FIFO contents or dp_valid. Errors detected on the same edge as err_clr are discarded.

Reset
REQ-019 HRESET=1 SHALL asynchronously force: FIFO empty; outstanding=0; dp_valid=0; timeout counter 0; all err_* = 0; err_count=0.
REQ-020 Reset asserted mid-transfer SHALL discard pending entries. After release, the first address phase with an empty FIFO sets err_underflow.

Verification
REQ-021 Matched write: push {adr=0x80, we=1, be=4'hF, d=0x12345678}; next cycle address phase HADDR=0x80, HWRITE=1, HSIZE=2; data HWDATA=0x12345678, HREADY=1 -> all err_*=0, outstanding 1->0.
REQ-022 Byte write: be=4'b0100, d=0x00AB0000; HSIZE=0; HWDATA=0xFFABFFFF -> no err_wdata. HWDATA=0x00CD0000 -> err_wdata=1, err_count=1.
REQ-023 Occupancy limits, DEPTH=4: 5 pushes, no AHB activity -> outstanding=4 and err_overflow=1. Then 5 address phases -> 4 pop correctly and the 5th sets err_underflow; err_count=2.
REQ-024 Bypass and pipelining: push plus address phase on the same edge, empty FIFO, HADDR matching -> no error, outstanding stays 0. Back-to-back NONSEQ/SEQ with wait states (HREADY=0 for 2 cycles) -> correct per-entry data checks.
REQ-025 Timeout/response/reset: TIMEOUT=8, one push, no AHB for 8 cycles -> err_timeout=1. HRESP=1 with HREADY=1 in a data phase -> err_resp=1. HRESET pulse mid-stream -> all outputs 0 immediately. err_clr -> flags and err_count 0, outstanding retained.
